// File: rtl/wb_uart_pkg.sv
// Shared definitions for wb_uart: register map, STATUS bit positions, FSM states.
// The optional STATUS loopback bit is only active when WB_UART_LOOPBACK_EN is defined.
package wb_uart_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;

  localparam int unsigned ST_TX_FULL      = 0;
  localparam int unsigned ST_TX_EMPTY     = 1;
  localparam int unsigned ST_TX_BUSY      = 2;
  localparam int unsigned ST_RX_VALID     = 3;
  localparam int unsigned ST_RX_OVERRUN   = 4;
  localparam int unsigned ST_RX_FRAME_ERR = 5;
  localparam int unsigned ST_LOOPBACK     = 8;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  function automatic logic [15:0] clamp_div(input logic [15:0] v);
    return (v < 16'd2) ? 16'd2 : v;
  endfunction

endpackage

// File: rtl/wb_uart_if.sv
// Wishbone classic bus bundle between the J1 data bus and the UART slave.
interface if_wb;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [1:0]  adr;
  logic [15:0] dat_m;
  logic [15:0] dat_s;
  logic        ack;

  modport master (output cyc, stb, we, adr, dat_m, input dat_s, ack);
  modport slave  (input cyc, stb, we, adr, dat_m, output dat_s, ack);
endinterface

// File: rtl/wb_uart_fifo.sv
// Circular-buffer FIFO with extra-MSB pointers; push on full and pop on empty are ignored.
module wb_uart_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty   = (wptr_q == rptr_q);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + PTR_ONE;
    if (do_pop)  rptr_d = rptr_q + PTR_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/wb_uart.sv
// Wishbone UART: TX FIFO + 8N1 serializer, 8N1 deserializer with one-byte holding register.
// Optional internal loopback (STATUS bit8) is enabled by defining WB_UART_LOOPBACK_EN.
module wb_uart
  import wb_uart_pkg::*;
#(
  parameter int unsigned TX_DEPTH  = 8,
  parameter logic [15:0] DIV_RESET = 16'd868
) (
  input  logic sys_clk_i,
  input  logic sys_rst_i,
  if_wb.slave  wb,
  output logic txd_o,
  input  logic rxd_i
);
  logic        ack_q, ack_d;
  logic [15:0] dat_s_q, dat_s_d;
  logic [15:0] div_q, div_d;
  logic        req, wr, rd, push, pop, data_rd, stat_rd;
  logic [7:0]  fifo_rdata;
  logic        tx_full, tx_empty, tx_line, rx_in;
  logic [15:0] status;

  uart_state_t tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d, tx_len_q, tx_len_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;

  uart_state_t rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d, rx_len_q, rx_len_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d, rx_byte_q, rx_byte_d;
  logic        rxd_meta_q, rxd_meta_d, rxd_sync_q, rxd_sync_d, rxd_prev_q, rxd_prev_d;
  logic        rx_valid_q, rx_valid_d, rx_ovr_q, rx_ovr_d, rx_ferr_q, rx_ferr_d;
  logic        rx_done, rx_bad;

  // Side effects commit on the same edge that raises ack, so read data and state change stay atomic.
  assign req     = wb.cyc & wb.stb & ~ack_q;
  assign wr      = req & wb.we;
  assign rd      = req & ~wb.we;
  assign data_rd = rd && (wb.adr == REG_DATA);
  assign stat_rd = rd && (wb.adr == REG_STATUS);
  assign wb.ack   = ack_q;
  assign wb.dat_s = dat_s_q;

`ifdef WB_UART_LOOPBACK_EN
  logic loop_q, loop_d;
  always_comb begin
    loop_d = loop_q;
    if (wr && (wb.adr == REG_STATUS)) loop_d = wb.dat_m[ST_LOOPBACK];
  end
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) loop_q <= 1'b0;
    else           loop_q <= loop_d;
  end
  assign rx_in = loop_q ? tx_line : rxd_i;
  assign txd_o = loop_q ? 1'b1 : tx_line;
`else
  assign rx_in = rxd_i;
  assign txd_o = tx_line;
`endif

  always_comb begin
    status                  = '0;
    status[ST_TX_FULL]      = tx_full;
    status[ST_TX_EMPTY]     = tx_empty;
    status[ST_TX_BUSY]      = (tx_state_q != IDLE);
    status[ST_RX_VALID]     = rx_valid_q;
    status[ST_RX_OVERRUN]   = rx_ovr_q;
    status[ST_RX_FRAME_ERR] = rx_ferr_q;
`ifdef WB_UART_LOOPBACK_EN
    status[ST_LOOPBACK]     = loop_q;
`endif
  end

  always_comb begin
    ack_d   = req;
    dat_s_d = '0;
    div_d   = div_q;
    push    = 1'b0;
    if (rd) begin
      case (wb.adr)
        REG_DATA:   dat_s_d = {8'h00, rx_byte_q};
        REG_STATUS: dat_s_d = status;
        REG_DIV:    dat_s_d = div_q;
        default:    dat_s_d = '0;
      endcase
    end
    if (wr) begin
      case (wb.adr)
        REG_DATA: push  = 1'b1;
        REG_DIV:  div_d = clamp_div(wb.dat_m);
        default: ;
      endcase
    end
  end

  wb_uart_fifo #(.DEPTH(TX_DEPTH), .WIDTH(8)) u_tx_fifo (
    .clk   (sys_clk_i),
    .rst   (sys_rst_i),
    .push  (push),
    .wdata (wb.dat_m[7:0]),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (tx_full),
    .empty (tx_empty)
  );

  // Bit length is latched at each bit boundary so a DIV write never stretches or wraps the current bit.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 16'd1;
    tx_len_d   = tx_len_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    pop        = 1'b0;
    tx_line    = 1'b1;
    case (tx_state_q)
      IDLE: begin
        tx_cnt_d = '0;
        tx_len_d = div_q;
        if (!tx_empty) begin
          pop        = 1'b1;
          tx_shift_d = fifo_rdata;
          tx_bit_d   = '0;
          tx_state_d = START;
        end
      end
      START: begin
        tx_line = 1'b0;
        if (tx_cnt_q >= tx_len_q - 16'd1) begin
          tx_cnt_d   = '0;
          tx_len_d   = div_q;
          tx_state_d = DATA;
        end
      end
      DATA: begin
        tx_line = tx_shift_q[0];
        if (tx_cnt_q >= tx_len_q - 16'd1) begin
          tx_cnt_d   = '0;
          tx_len_d   = div_q;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_bit_d   = tx_bit_q + 3'd1;
          if (tx_bit_q == 3'd7) tx_state_d = STOP;
        end
      end
      STOP: begin
        if (tx_cnt_q >= tx_len_q - 16'd1) begin
          tx_cnt_d   = '0;
          tx_state_d = IDLE;
        end
      end
      default: tx_state_d = IDLE;
    endcase
  end

  always_comb begin
    rxd_meta_d = rx_in;
    rxd_sync_d = rxd_meta_q;
    rxd_prev_d = rxd_sync_q;
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 16'd1;
    rx_len_d   = rx_len_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_done    = 1'b0;
    rx_bad     = 1'b0;
    case (rx_state_q)
      IDLE: begin
        rx_cnt_d = '0;
        rx_len_d = div_q;
        if (rxd_prev_q && !rxd_sync_q) rx_state_d = START;
      end
      START: begin
        if (rx_cnt_q >= {1'b0, rx_len_q[15:1]} - 16'd1) begin
          rx_cnt_d   = '0;
          rx_len_d   = div_q;
          rx_bit_d   = '0;
          rx_state_d = rxd_sync_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (rx_cnt_q >= rx_len_q - 16'd1) begin
          rx_cnt_d   = '0;
          rx_len_d   = div_q;
          rx_shift_d = {rxd_sync_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = STOP;
        end
      end
      STOP: begin
        if (rx_cnt_q >= rx_len_q - 16'd1) begin
          rx_cnt_d   = '0;
          rx_state_d = IDLE;
          rx_done    = rxd_sync_q;
          rx_bad     = ~rxd_sync_q;
        end
      end
      default: rx_state_d = IDLE;
    endcase
  end

  // A completing byte wins over a simultaneous CPU read; the read already captured the old byte.
  always_comb begin
    rx_byte_d  = rx_done ? rx_shift_q : rx_byte_q;
    rx_valid_d = rx_valid_q;
    rx_ovr_d   = rx_ovr_q;
    rx_ferr_d  = rx_ferr_q;
    if (data_rd) rx_valid_d = 1'b0;
    if (rx_done) rx_valid_d = 1'b1;
    if (stat_rd) begin
      rx_ovr_d  = 1'b0;
      rx_ferr_d = 1'b0;
    end
    if (rx_done && rx_valid_q && !data_rd) rx_ovr_d = 1'b1;
    if (rx_bad) rx_ferr_d = 1'b1;
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      ack_q      <= 1'b0;
      dat_s_q    <= '0;
      div_q      <= DIV_RESET;
      tx_state_q <= IDLE;
      tx_cnt_q   <= '0;
      tx_len_q   <= DIV_RESET;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      rx_state_q <= IDLE;
      rx_cnt_q   <= '0;
      rx_len_q   <= DIV_RESET;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_byte_q  <= '0;
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      rxd_prev_q <= 1'b1;
      rx_valid_q <= 1'b0;
      rx_ovr_q   <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      ack_q      <= ack_d;
      dat_s_q    <= dat_s_d;
      div_q      <= div_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_len_q   <= tx_len_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_len_q   <= rx_len_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_byte_q  <= rx_byte_d;
      rxd_meta_q <= rxd_meta_d;
      rxd_sync_q <= rxd_sync_d;
      rxd_prev_q <= rxd_prev_d;
      rx_valid_q <= rx_valid_d;
      rx_ovr_q   <= rx_ovr_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end
endmodule
